bg_pixel_fifo: RTL and testbench
================================

# bg_pixel_fifo

Background pixel FIFO for the PPU, directly downstream of the background/window fetcher. It accepts 8-pixel tile rows (low/high bitplanes) from the fetcher and shifts out one pixel per T-cycle. It drops the SCX fine-scroll pixels at line start, maps colour indices through BGP, and tracks the LCD X position. It also tells the fetcher when it may push.

## Interface
- DEPTH, 16: pixel entries; power of two, at least 16.
- X_MAX, 160: visible pixels per scanline.
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- tclk_in  in  1  T-cycle enable, one clk_in cycle wide.
- line_start_in  in  1  pulse at the start of mode 3; flushes the FIFO and re-arms the line.
- scx_fine_in  in  3  SCX[2:0]; sampled on line_start_in.
- push_valid_in  in  1  fetcher has a tile row.
- push_ready_out  out  1  FIFO can accept 8 pixels.
- tile_low_in  in  8  low bitplane, bit 7 is the leftmost pixel.
- tile_high_in  in  8  high bitplane.
- bgp_in  in  8  BGP palette register.
- bg_enable_in  in  1  LCDC.0; when 0, every colour index is forced to 0.
- pixel_valid_out  out  1  one-cycle strobe, pixel written to the LCD.
- color_index_out  out  2  raw colour index (for sprite priority downstream).
- shade_out  out  2  BGP-mapped shade.
- x_out  out  8  X of the pixel on the outputs, 0..X_MAX-1.
- line_done_out  out  1  all X_MAX pixels emitted; sticky.
- level_out  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Storage:** a circular buffer of 2-bit colour indices, with a read pointer, a write pointer and a level counter.
- **Push:**
  - Accepted on any clk_in edge where push_valid_in && push_ready_out; tclk_in is not required.
  - The 8 entries written are {tile_high_in[7-i], tile_low_in[7-i]} for i = 0..7, leftmost first.
- **push_ready_out:** equals (level <= DEPTH-8) && !line_done.
- **Pop:**
  - Occurs on a tclk_in cycle when level > 0 and !line_done.
  - Removes exactly one entry.
- **Discard:**
  - line_start_in loads discard_cnt <= scx_fine_in.
  - While discard_cnt != 0, each pop decrements discard_cnt. It does not strobe pixel_valid_out and does not advance X.
- **Emit:**
  - A non-discarded pop registers color_index_out = bg_enable_in ? idx : 0.
  - shade_out = bgp_in[2*c+1 : 2*c], where c is the registered color index.
  - x_out takes the current X, pixel_valid_out goes to 1, then X increments.
- **End of line:** when the emitted pixel has X = X_MAX-1, line_done is set.
  - line_done is cleared only by line_start_in or reset.
  - While line_done is set, the block pops nothing and accepts no push.
- **Simultaneous push and pop:** level <= level + 8 - 1. Read and write pointers wrap modulo DEPTH.
- **Priority:** reset > line_start_in > push/pop. If line_start_in arrives in the same cycle as a push or pop, the push/pop is ignored and the block does the following:
  - Pointers and level go to 0.
  - X goes to 0 and line_done to 0.
  - discard_cnt is loaded.
- **Mid-operation events:**
  - Asserting rst_in mid-line clears everything immediately.
  - Asserting line_start_in mid-line flushes the FIFO; pixels not yet popped are lost and nothing further is emitted.

## Timing
- **Reset values:**
  - push_ready_out = 1 (level 0, line_done 0).
  - pixel_valid_out = 0, color_index_out = 0, shade_out = 0.
  - x_out = 0, line_done_out = 0, level_out = 0.
- **Pop latency:** the pop occurs on a tclk_in edge; outputs are valid on the following clk_in edge; pixel_valid_out is high for exactly one clk_in cycle.
- **Push latency:** pixels pushed at edge N become poppable at the first tclk_in edge after N. If the FIFO is empty, a push and a tclk_in in the same cycle produce no pop.
- **Combinational outputs:** push_ready_out and level_out are combinational from registered state, with no path from push_valid_in.
- **Throughput:** at most one emitted pixel per T-cycle. X_MAX + scx_fine pops per line when the FIFO never starves.

## Structure
- Package ppu_pkg holds X_MAX, the tile-row width constant (8) and a typedef color_idx_t (logic [1:0]); the fetcher shares these.
- One sub-module, pixel_ring: a DEPTH x 2 circular buffer with an 8-wide write port, a 1-wide read port and level tracking. Discard, X counter and palette logic stay in bg_pixel_fifo.

## Test plan
- **Reset:** hold rst_in = 0 mid-push -> all outputs at reset values, push_ready_out = 1, level_out = 0.
- **Basic row:** line_start with scx_fine = 0, push low = 8'hF0, high = 8'hAA, BGP = 8'hE4 -> indices 3,1,3,1,2,0,2,0 at x 0..7, shades equal to the indices, 8 strobes.
- **Fine scroll:** scx_fine = 5, push one row -> first emitted pixel is row pixel 5 at x_out = 0, 3 strobes, level 0.
- **Full and simultaneous traffic:**
  - Two pushes with no tclk_in -> level 16, push_ready_out = 0.
  - One pop -> ready stays 0 until level is 8.
  - Push and pop in the same cycle at level 8 -> level 15.
- **End of line:** 20 rows pushed back to back -> exactly 160 strobes, x_out 0..159, line_done_out = 1 after the last, further tclk_in gives no strobes, push_ready_out = 0.
- **Flush and palette:**
  - line_start_in mid-line with level 6 -> level 0, x_out 0, line_done 0.
  - bg_enable_in = 0 with BGP = 8'h1B -> color_index_out 0, shade 3 on every pixel.

Source files
------------

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU constants and types shared by the fetcher and the background pixel FIFO
package ppu_pkg;

  localparam int X_MAX  = 160;
  localparam int TILE_W = 8;

  typedef logic [1:0] color_idx_t;

endpackage

// File: rtl/bg_pixel_fifo_pixel_ring.sv
// rtl/bg_pixel_fifo_pixel_ring.sv - DEPTH x 2 circular buffer, 8-wide write, 1-wide read, level tracking
module pixel_ring #(
  parameter int DEPTH = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      push_in,
  input  logic [15:0]               wr_data_in,
  input  logic                      pop_in,
  output logic [1:0]                rd_data_out,
  output logic [$clog2(DEPTH):0]    level_out
);
  import ppu_pkg::TILE_W;
  import ppu_pkg::color_idx_t;

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  color_idx_t        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  assign rd_data_out = mem_q[rd_ptr_q];
  assign level_out   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_in) wr_ptr_d = wr_ptr_q + PW'(TILE_W);
      if (pop_in)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + (push_in ? LW'(TILE_W) : LW'(0)) - (pop_in ? LW'(1) : LW'(0));
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once the level says they were written.
  always_ff @(posedge clk_in) begin
    if (push_in && !flush_in) begin
      for (int i = 0; i < TILE_W; i++) begin
        mem_q[wr_ptr_q + PW'(i)] <= wr_data_in[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/bg_pixel_fifo.sv
// rtl/bg_pixel_fifo.sv - background pixel FIFO: fine-scroll discard, BGP mapping, LCD X tracking
module bg_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int X_MAX = ppu_pkg::X_MAX
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   tclk_in,
  input  logic                   line_start_in,
  input  logic [2:0]             scx_fine_in,
  input  logic                   push_valid_in,
  output logic                   push_ready_out,
  input  logic [7:0]             tile_low_in,
  input  logic [7:0]             tile_high_in,
  input  logic [7:0]             bgp_in,
  input  logic                   bg_enable_in,
  output logic                   pixel_valid_out,
  output logic [1:0]             color_index_out,
  output logic [1:0]             shade_out,
  output logic [7:0]             x_out,
  output logic                   line_done_out,
  output logic [$clog2(DEPTH):0] level_out
);
  import ppu_pkg::TILE_W;
  import ppu_pkg::color_idx_t;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] READY_MAX = LW'(DEPTH - TILE_W);
  localparam logic [7:0]    X_LAST    = 8'(X_MAX - 1);

  logic [LW-1:0]         level;
  color_idx_t            rd_idx;
  color_idx_t            emit_idx;
  logic [2*TILE_W-1:0]   row;
  logic                  push, pop;

  logic [2:0] discard_q, discard_d;
  logic [7:0] x_q, x_d;
  logic       line_done_q, line_done_d;
  logic       valid_q, valid_d;
  color_idx_t cidx_q, cidx_d;
  logic [1:0] shade_q, shade_d;
  logic [7:0] xo_q, xo_d;

  always_comb begin
    row = '0;
    for (int i = 0; i < TILE_W; i++) begin
      row[2*i +: 2] = {tile_high_in[TILE_W-1-i], tile_low_in[TILE_W-1-i]};
    end
  end

  assign push_ready_out = (level <= READY_MAX) && !line_done_q;
  assign push = push_valid_in && push_ready_out && !line_start_in;
  assign pop  = tclk_in && (level != '0) && !line_done_q && !line_start_in;

  pixel_ring #(.DEPTH(DEPTH)) u_ring (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (line_start_in),
    .push_in     (push),
    .wr_data_in  (row),
    .pop_in      (pop),
    .rd_data_out (rd_idx),
    .level_out   (level)
  );

  assign emit_idx = bg_enable_in ? rd_idx : 2'b00;

  always_comb begin
    discard_d   = discard_q;
    x_d         = x_q;
    line_done_d = line_done_q;
    valid_d     = 1'b0;
    cidx_d      = cidx_q;
    shade_d     = shade_q;
    xo_d        = xo_q;
    if (line_start_in) begin
      discard_d   = scx_fine_in;
      x_d         = '0;
      line_done_d = 1'b0;
      cidx_d      = '0;
      shade_d     = '0;
      xo_d        = '0;
    end else if (pop) begin
      // Fine-scroll pixels are consumed silently before X starts counting.
      if (discard_q != 3'd0) begin
        discard_d = discard_q - 3'd1;
      end else begin
        cidx_d  = emit_idx;
        shade_d = bgp_in[{emit_idx, 1'b0} +: 2];
        xo_d    = x_q;
        valid_d = 1'b1;
        x_d     = x_q + 8'd1;
        if (x_q == X_LAST) line_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      discard_q   <= '0;
      x_q         <= '0;
      line_done_q <= 1'b0;
      valid_q     <= 1'b0;
      cidx_q      <= '0;
      shade_q     <= '0;
      xo_q        <= '0;
    end else begin
      discard_q   <= discard_d;
      x_q         <= x_d;
      line_done_q <= line_done_d;
      valid_q     <= valid_d;
      cidx_q      <= cidx_d;
      shade_q     <= shade_d;
      xo_q        <= xo_d;
    end
  end

  assign pixel_valid_out = valid_q;
  assign color_index_out = cidx_q;
  assign shade_out       = shade_q;
  assign x_out           = xo_q;
  assign line_done_out   = line_done_q;
  assign level_out       = level;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// tb/tb_bg_pixel_fifo.sv - self-checking bench for bg_pixel_fifo with a queue-based line model
module tb_bg_pixel_fifo;

  localparam int DEPTH = 16;
  localparam int X_MAX = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tclk = 1'b0;
  logic       line_start = 1'b0;
  logic [2:0] scx = 3'd0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [7:0] tlow = 8'h00;
  logic [7:0] thigh = 8'h00;
  logic [7:0] bgp = 8'h00;
  logic       bg_en = 1'b1;
  logic       pv;
  logic [1:0] cidx;
  logic [1:0] shade;
  logic [7:0] xo;
  logic       ldone;
  logic [4:0] level;

  bg_pixel_fifo #(.DEPTH(DEPTH), .X_MAX(X_MAX)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .tclk_in         (tclk),
    .line_start_in   (line_start),
    .scx_fine_in     (scx),
    .push_valid_in   (push_valid),
    .push_ready_out  (push_ready),
    .tile_low_in     (tlow),
    .tile_high_in    (thigh),
    .bgp_in          (bgp),
    .bg_enable_in    (bg_en),
    .pixel_valid_out (pv),
    .color_index_out (cidx),
    .shade_out       (shade),
    .x_out           (xo),
    .line_done_out   (ldone),
    .level_out       (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Line model: a queue of colour indices plus the line's X / discard / done state.
  int m_q[$];
  int m_x = 0, m_disc = 0, m_done = 0;
  int m_pv = 0, m_ci = 0, m_sh = 0, m_xo = 0;
  int log_idx[$], log_sh[$], log_x[$];

  task automatic model_step();
    int ready, idx;
    bit do_pop, do_push;
    ready = (m_q.size() <= DEPTH - 8 && m_done == 0) ? 1 : 0;
    if (!rst_n) begin
      m_q.delete(); m_x = 0; m_disc = 0; m_done = 0;
      m_pv = 0; m_ci = 0; m_sh = 0; m_xo = 0;
    end else if (line_start) begin
      m_q.delete(); m_x = 0; m_disc = int'(scx); m_done = 0;
      m_pv = 0; m_ci = 0; m_sh = 0; m_xo = 0;
    end else begin
      m_pv = 0;
      do_pop  = tclk && m_q.size() > 0 && m_done == 0;
      do_push = push_valid && ready == 1;
      if (do_pop) begin
        idx = m_q.pop_front();
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          m_ci = bg_en ? idx : 0;
          m_sh = (int'(bgp) >> (2 * m_ci)) & 3;
          m_xo = m_x;
          m_pv = 1;
          if (m_x == X_MAX - 1) m_done = 1;
          m_x++;
        end
      end
      if (do_push) begin
        for (int i = 0; i < 8; i++) m_q.push_back(int'(thigh[7-i]) * 2 + int'(tlow[7-i]));
      end
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    #3;
    check("pixel_valid", int'(pv), m_pv);
    check("level", int'(level), m_q.size());
    check("push_ready", int'(push_ready), (m_q.size() <= DEPTH - 8 && m_done == 0) ? 1 : 0);
    check("line_done", int'(ldone), m_done);
    check("color_index", int'(cidx), m_ci);
    check("shade", int'(shade), m_sh);
    check("x_out", int'(xo), m_xo);
    if (pv === 1'b1) begin
      log_idx.push_back(int'(cidx));
      log_sh.push_back(int'(shade));
      log_x.push_back(int'(xo));
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #6;
    end
  endtask

  task automatic start_line(input int s);
    scx = 3'(s);
    line_start = 1'b1;
    run(1);
    line_start = 1'b0;
  endtask

  task automatic push_row(input logic [7:0] l, input logic [7:0] h);
    tlow = l; thigh = h; push_valid = 1'b1;
    run(1);
    push_valid = 1'b0;
  endtask

  task automatic pops(input int n);
    repeat (n) begin
      tclk = 1'b1; run(1);
      tclk = 1'b0; run(1);
    end
  endtask

  task automatic clear_log();
    log_idx.delete(); log_sh.delete(); log_x.delete();
  endtask

  int exp_basic[8] = '{3, 1, 3, 1, 2, 0, 2, 0};
  int rows, cyc;
  bit accept;

  initial begin
    // Reset values
    run(3);
    check("rst_level", int'(level), 0);
    check("rst_ready", int'(push_ready), 1);
    check("rst_valid", int'(pv), 0);
    check("rst_x", int'(xo), 0);
    check("rst_done", int'(ldone), 0);
    check("rst_shade", int'(shade), 0);
    rst_n = 1'b1;
    run(1);

    // Reset asserted while a push is in flight
    bgp = 8'hE4; bg_en = 1'b1;
    start_line(0);
    tlow = 8'hF0; thigh = 8'hAA; push_valid = 1'b1;
    run(1);
    check("pre_rst_level", int'(level), 8);
    rst_n = 1'b0;
    #1;
    check("midrst_level", int'(level), 0);
    check("midrst_ready", int'(push_ready), 1);
    check("midrst_valid", int'(pv), 0);
    check("midrst_color", int'(cidx), 0);
    run(2);
    rst_n = 1'b1; push_valid = 1'b0;
    run(1);

    // Basic row
    clear_log();
    start_line(0);
    push_row(8'hF0, 8'hAA);
    pops(10);
    check("basic_strobes", log_idx.size(), 8);
    for (int i = 0; i < 8 && i < log_idx.size(); i++) begin
      check("basic_idx", log_idx[i], exp_basic[i]);
      check("basic_shade", log_sh[i], exp_basic[i]);
      check("basic_x", log_x[i], i);
    end

    // Fine scroll of 5
    clear_log();
    start_line(5);
    push_row(8'hF0, 8'hAA);
    pops(10);
    check("scroll_strobes", log_idx.size(), 3);
    if (log_idx.size() == 3) begin
      check("scroll_idx0", log_idx[0], 0);
      check("scroll_x0", log_x[0], 0);
      check("scroll_idx1", log_idx[1], 2);
      check("scroll_idx2", log_idx[2], 0);
      check("scroll_x2", log_x[2], 2);
    end
    check("scroll_level", int'(level), 0);

    // Full and simultaneous traffic
    start_line(0);
    tlow = 8'h3C; thigh = 8'h5A; push_valid = 1'b1;
    run(2);
    push_valid = 1'b0;
    check("full_level", int'(level), 16);
    check("full_ready", int'(push_ready), 0);
    pops(7);
    check("l9_level", int'(level), 9);
    check("l9_ready", int'(push_ready), 0);
    pops(1);
    check("l8_ready", int'(push_ready), 1);
    push_valid = 1'b1; tclk = 1'b1;
    run(1);
    push_valid = 1'b0; tclk = 1'b0;
    check("pushpop_level", int'(level), 15);

    // End of line
    clear_log();
    start_line(0);
    rows = 0; cyc = 0;
    while (ldone !== 1'b1 && cyc < 1000) begin
      tclk = cyc[0];
      push_valid = (rows < 20);
      tlow = 8'(rows * 37 + 5); thigh = 8'(rows * 91 + 3);
      accept = push_valid && push_ready;
      run(1);
      if (accept) rows++;
      cyc++;
    end
    tclk = 1'b0; push_valid = 1'b0;
    check("eol_in_time", (cyc < 1000) ? 1 : 0, 1);
    check("eol_rows", rows, 20);
    check("eol_strobes", log_x.size(), 160);
    for (int i = 0; i < log_x.size(); i++) check("eol_x", log_x[i], i);
    check("eol_done", int'(ldone), 1);
    pops(5);
    check("eol_no_more", log_x.size(), 160);
    check("eol_ready", int'(push_ready), 0);

    // Mid-line flush (line_start wins over a concurrent push and pop)
    clear_log();
    start_line(0);
    push_row(8'hF0, 8'hAA);
    pops(2);
    check("flush_pre_level", int'(level), 6);
    scx = 3'd3; line_start = 1'b1; tclk = 1'b1; push_valid = 1'b1;
    run(1);
    line_start = 1'b0; tclk = 1'b0; push_valid = 1'b0;
    check("flush_level", int'(level), 0);
    check("flush_x", int'(xo), 0);
    check("flush_done", int'(ldone), 0);
    clear_log();
    pops(3);
    check("flush_no_emit", log_x.size(), 0);

    // Background disabled with BGP 1B
    clear_log();
    bgp = 8'h1B; bg_en = 1'b0;
    start_line(0);
    push_row(8'hF0, 8'hAA);
    pops(10);
    check("pal_strobes", log_idx.size(), 8);
    for (int i = 0; i < log_idx.size(); i++) begin
      check("pal_idx", log_idx[i], 0);
      check("pal_shade", log_sh[i], 3);
    end

    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
